load_store_unit: RTL and testbench

MEM-stage load/store sequencer sitting directly upstream of the word-addressed data memory. Accepts one byte-addressed load/store request per transaction from the EX/MEM pipeline register. Translates it into word-index rd/wr accesses and performs read-modify-write for sub-word stores. Returns sign/zero-extended load data or an error, and stalls the pipeline via req_ready.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 74 +++++++
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store sequencer.
//   - request size encodings (byte / half / word / reserved)
//   - sequencer state enum
//   - byte-lane width used by the lane alignment logic
package lsu_pkg;

  // Width of one byte lane inside the 32-bit data word.
  localparam int LANE_W = 8;

  // Encodings of the req_size field.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane logic.
//   Loads : picks the addressed byte/half out of word_i and sign- or
//           zero-extends it; a word load passes word_i straight through.
//   Stores: replaces only the addressed byte/half of word_i with the low
//           bits of wdata_i; a word store yields wdata_i unchanged.
// Ports:
//   addr_lo_i   [1:0]  byte offset within the word
//   size_i      [1:0]  access size (lsu_pkg SZ_* encodings)
//   unsigned_i         1 = zero-extend loads, 0 = sign-extend
//   word_i      [31:0] memory word being read or modified
//   wdata_i     [31:0] right-justified store data
//   load_data_o [31:0] extended load result
//   merged_o    [31:0] word to write back for a store
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_src;
  logic [31:0] half_src;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;
  logic [31:0] byte_ins;
  logic [31:0] half_ins;

  // Lane offsets: a byte sits at 8*addr[1:0], a half at 16*addr[1].
  always_comb begin
    byte_sh  = {3'b000, addr_lo_i} * 5'(LANE_W);
    half_sh  = {4'b0000, addr_lo_i[1]} * 5'(2 * LANE_W);
    byte_src = word_i >> byte_sh;
    half_src = word_i >> half_sh;
    byte_val = byte_src[7:0];
    half_val = half_src[15:0];
  end

  // Load extraction and extension.
  always_comb begin
    load_data_o = word_i;
    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h000000, byte_val}
                                        : {{24{byte_val[7]}}, byte_val};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0000, half_val}
                                        : {{16{half_val[15]}}, half_val};
      default: load_data_o = word_i;
    endcase
  end

  // Store merge: clear the addressed lane, then OR in the new bits.
  always_comb begin
    byte_mask = 32'h0000_00FF << byte_sh;
    half_mask = 32'h0000_FFFF << half_sh;
    byte_ins  = {24'h000000, wdata_i[7:0]} << byte_sh;
    half_ins  = {16'h0000, wdata_i[15:0]} << half_sh;
    merged_o  = word_i;
    case (size_i)
      SZ_BYTE: merged_o = (word_i & ~byte_mask) | byte_ins;
      SZ_HALF: merged_o = (word_i & ~half_mask) | half_ins;
      SZ_WORD: merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store sequencer in front of a
// word-addressed data memory. Takes one byte-addressed request at a time,
// turns it into word-index reads/writes (read-modify-write for sub-word
// stores) and returns extended load data or an error.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//   resp_valid, resp_rdata, resp_err                     one-cycle response
//   mem_addr, mem_wdata, mem_rdata, mem_rd, mem_wr       memory side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  state_t state_q, state_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rword_q;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        acc_err;
  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Error classification of the incoming request, evaluated at accept.
  always_comb begin
    accept  = (state_q == S_IDLE) && req_valid;
    acc_err = (req_size == SZ_RSVD)
            || ((req_size == SZ_HALF) && req_addr[0])
            || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
            || ({2'b00, req_addr[31:2]} >= MEM_WORDS_L);
  end

  // During RD the lane logic sees live memory data (load extract);
  // in WR it sees the word captured in RD (store merge).
  assign align_word = (state_q == S_RD) ? mem_rdata : rword_q;

  lsu_lane_align u_align (
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .word_i      (align_word),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Full-word stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_err) begin
            state_d = S_RESP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the word index is only driven while a
  // memory strobe is active.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_RD: begin
        mem_rd   = 1'b1;
        mem_addr = {2'b00, addr_q[31:2]};
      end
      S_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = {2'b00, addr_q[31:2]};
        mem_wdata = merged;
      end
      S_RESP:  resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Response values are loaded on the transition into RESP and held
  // until the next response.
  always_comb begin
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept && acc_err) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
        end
      end
      S_RD: begin
        if (!we_q) begin
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
        end
      end
      S_WR: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
      default: begin
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
      end
    endcase
  end

  // Request capture, RD word capture and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rword_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_RD) begin
        rword_q <= mem_rdata;
      end
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit. A word
// memory answers the DUT; a byte-array reference model predicts every
// response and every memory write.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memRd;
  logic        memWr;

  logic [31:0] memWords [0:1023];
  logic [7:0]  refBytes [0:4095];

  int checksTotal = 0;
  int checksPassed = 0;
  int bothHigh = 0;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_WORDS(1024), .DATA_W(32)) dut (
    .clk          (clock),
    .rst_n        (rstN),
    .req_valid    (reqValid),
    .req_ready    (reqReady),
    .req_we       (reqWe),
    .req_size     (reqSize),
    .req_unsigned (reqUnsigned),
    .req_addr     (reqAddr),
    .req_wdata    (reqWdata),
    .resp_valid   (respValid),
    .resp_rdata   (respRdata),
    .resp_err     (respErr),
    .mem_addr     (memAddr),
    .mem_wdata    (memWdata),
    .mem_rdata    (memRdata),
    .mem_rd       (memRd),
    .mem_wr       (memWr)
  );

  // Word-addressed data memory with combinational read.
  assign memRdata = (memAddr < 32'd1024) ? memWords[memAddr[9:0]] : 32'h0;

  always @(posedge clock) begin
    if (memWr && (memAddr < 32'd1024)) memWords[memAddr[9:0]] <= memWdata;
  end

  // Read and write strobes must never overlap.
  always @(negedge clock) begin
    if (memRd && memWr) bothHigh++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] refWord(input int idx);
    return {refBytes[4*idx+3], refBytes[4*idx+2], refBytes[4*idx+1], refBytes[4*idx]};
  endfunction

  // Reference: byte-array memory, little-endian, errors by plain arithmetic.
  task automatic modelRequest(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic expErr, output logic [31:0] expData);
    int nBytes;
    int a;
    logic [31:0] value;
    nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    expErr = (size == 2'd3) || (addr % nBytes != 0) || (addr >= 32'd4096);
    expData = 32'h0;
    if (!expErr) begin
      a = int'(addr[11:0]);
      if (!we) begin
        value = 32'h0;
        for (int i = 0; i < nBytes; i++) value = value | (32'(refBytes[a+i]) << (8*i));
        if (nBytes < 4 && !uns && value[8*nBytes-1]) value = value | ~((32'h1 << (8*nBytes)) - 1);
        expData = value;
      end else begin
        for (int i = 0; i < nBytes; i++) refBytes[a+i] = 8'((wdata >> (8*i)) & 32'hFF);
      end
    end
  endtask

  // One isolated transaction: latency, strobes, write data and response.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] obsData, output logic obsErr);
    logic expErr;
    logic [31:0] expData;
    logic [31:0] expWord;
    int expLat, respAt, rdCnt, wrCnt, expRd, expWr;
    @(negedge clock);
    reqValid = 1'b1; reqWe = we; reqSize = size; reqUnsigned = uns;
    reqAddr = addr; reqWdata = wdata;
    checkOutput("req_ready_idle", 32'(reqReady), 32'd1);
    modelRequest(we, size, uns, addr, wdata, expErr, expData);
    expWord = (addr < 32'd4096) ? refWord(int'(addr[11:2])) : 32'h0;
    expLat = expErr ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));
    expRd  = (!expErr && !(we && size == 2'd2)) ? 1 : 0;
    expWr  = (!expErr && we) ? 1 : 0;
    @(posedge clock); #1;
    reqValid = 1'b0; reqWe = $urandom_range(0, 1); reqAddr = $urandom; reqWdata = $urandom;
    respAt = 0; rdCnt = 0; wrCnt = 0; obsData = 32'h0; obsErr = 1'b0;
    for (int k = 1; k <= 6 && respAt == 0; k++) begin
      if (respValid) begin
        respAt = k; obsData = respRdata; obsErr = respErr;
      end
      if (memRd) begin
        rdCnt++;
        checkOutput("rd_addr", memAddr, {2'b00, addr[31:2]});
      end
      if (memWr) begin
        wrCnt++;
        checkOutput("wr_addr", memAddr, {2'b00, addr[31:2]});
        checkOutput("wr_data", memWdata, expWord);
      end
      if (!memRd && !memWr) checkOutput("addr_zero", memAddr, 32'h0);
      checkOutput("ready_busy", 32'(reqReady), 32'd0);
      @(posedge clock); #1;
    end
    checkOutput("latency", 32'(respAt), 32'(expLat));
    checkOutput("resp_err", 32'(obsErr), 32'(expErr));
    checkOutput("resp_rdata", obsData, expData);
    checkOutput("rd_strobes", 32'(rdCnt), 32'(expRd));
    checkOutput("wr_strobes", 32'(wrCnt), 32'(expWr));
  endtask

  // req_valid held high across alternating stores/loads.
  task automatic streamTest(input int n);
    logic        sWe   [0:15];
    logic [1:0]  sSize [0:15];
    logic        sUns  [0:15];
    logic [31:0] sAddr [0:15];
    logic [31:0] sData [0:15];
    logic [32:0] expQ [$];
    logic [32:0] e;
    logic eErr, took;
    logic [31:0] eData;
    int idx, got, acc;
    for (int i = 0; i < n; i++) begin
      sWe[i] = (i % 2 == 0); sSize[i] = 2'($urandom_range(0, 2)); sUns[i] = 1'($urandom_range(0, 1));
      sAddr[i] = 32'($urandom_range(0, 7) * 4) + ((sSize[i] == 2'd0) ? 32'($urandom_range(0, 3)) :
                 (sSize[i] == 2'd1) ? 32'($urandom_range(0, 1) * 2) : 32'd0);
      if (i == 5) sSize[i] = 2'd3;
      sData[i] = $urandom;
    end
    idx = 0; got = 0; acc = 0;
    @(negedge clock);
    reqValid = 1'b1; reqWe = sWe[0]; reqSize = sSize[0]; reqUnsigned = sUns[0];
    reqAddr = sAddr[0]; reqWdata = sData[0];
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (respValid) begin
        if (expQ.size() == 0) checkOutput("stream_extra_resp", 32'd1, 32'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("stream_err", 32'(respErr), 32'(e[32]));
          checkOutput("stream_rdata", respRdata, e[31:0]);
        end
        got++;
      end
      took = reqValid && reqReady;
      if (took) begin
        modelRequest(reqWe, reqSize, reqUnsigned, reqAddr, reqWdata, eErr, eData);
        expQ.push_back({eErr, eData});
        acc++;
      end
      @(posedge clock); #1;
      if (took) begin
        idx++;
        if (idx < n) begin
          reqWe = sWe[idx]; reqSize = sSize[idx]; reqUnsigned = sUns[idx];
          reqAddr = sAddr[idx]; reqWdata = sData[idx];
        end else reqValid = 1'b0;
      end
    end
    reqValid = 1'b0;
    checkOutput("stream_accepted", 32'(acc), 32'(n));
    checkOutput("stream_responses", 32'(got), 32'(n));
  endtask

  initial begin
    logic [31:0] d;
    logic er;
    logic [31:0] rAddr;
    int pulses;
    for (int i = 0; i < 1024; i++) memWords[i] = $urandom;
    memWords[5] = 32'h8899AABB;
    for (int i = 0; i < 4096; i++) refBytes[i] = 8'((memWords[i/4] >> (8*(i%4))) & 32'hFF);

    rstN = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
    reqAddr = 32'h0; reqWdata = 32'h0;
    #12;
    checkOutput("rst_ready", 32'(reqReady), 32'd1);
    checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
    checkOutput("rst_resp_rdata", respRdata, 32'h0);
    checkOutput("rst_resp_err", 32'(respErr), 32'd0);
    checkOutput("rst_strobes", {30'h0, memRd, memWr}, 32'h0);
    checkOutput("rst_mem_addr", memAddr, 32'h0);
    checkOutput("rst_mem_wdata", memWdata, 32'h0);
    @(negedge clock); rstN = 1'b1;

    // Directed cases.
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, d, er);
    checkOutput("lb_0x15", d, 32'hFFFFFFAA);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h15, 32'h0, d, er);
    checkOutput("lbu_0x15", d, 32'h000000AA);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h16, 32'h00001234, d, er);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, d, er);
    checkOutput("lw_after_sh", d, 32'h1234AABB);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, d, er);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, d, er);
    checkOutput("lw_0x8", d, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, d, er);
    checkOutput("err_lw_0x6", 32'(er), 32'd1);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, d, er);
    checkOutput("err_lh_0x3", 32'(er), 32'd1);
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h10, 32'h5555, d, er);
    checkOutput("err_rsvd", 32'(er), 32'd1);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, d, er);
    checkOutput("err_range", 32'(er), 32'd1);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, d, er);
    checkOutput("last_word_ok", 32'(er), 32'd0);

    // Randomized isolated transactions.
    for (int t = 0; t < 40; t++) begin
      rAddr = ($urandom_range(0, 7) == 0) ? (32'h1000 + 32'($urandom_range(0, 255))) :
              32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    rAddr, $urandom, d, er);
    end

    @(posedge clock);
    streamTest(12);
    repeat (4) @(posedge clock);

    // Reset during the RD phase of a sub-word store.
    @(negedge clock);
    reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'd0; reqAddr = 32'h21; reqWdata = 32'h000000C3;
    @(posedge clock); #1;
    reqValid = 1'b0;
    checkOutput("mid_rst_rd_phase", 32'(memRd), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid_rst_rd_drop", 32'(memRd), 32'd0);
    checkOutput("mid_rst_ready", 32'(reqReady), 32'd1);
    pulses = 0;
    @(negedge clock); @(negedge clock); rstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (respValid || memWr || memRd) pulses++;
    end
    checkOutput("mid_rst_no_activity", 32'(pulses), 32'd0);
    checkOutput("mid_rst_ready_after", 32'(reqReady), 32'd1);
    checkOutput("mid_rst_mem_unchanged", memWords[8], refWord(8));

    checkOutput("rd_wr_exclusive", 32'(bothHigh), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  // Watchdog for a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
